// File: rtl/slewrate_sequencer.sv
// slewrate_sequencer
//
// Walks the I/O banks in ascending order and moves each bank's slew-enable
// bit to a requested value. After every bit change it waits SETTLE_CYCLES
// clocks so that the bank controller can settle before the next change.
// At most one SLEWRATEENO bit changes per clock.
//
// Parameters:
//   NUM_BANKS      number of banks driven (1..16)
//   SETTLE_CYCLES  settle wait after each changed bank (1..65535)
//   INIT_VALUE     SLEWRATEENO value after reset
//
// Ports:
//   CLK          rising-edge clock
//   RSTN         asynchronous active-low reset
//   REQ          request to apply TARGET; accepted when READY is high
//   TARGET       requested per-bank slew-enable values
//   ABORT        (only with SLEWRATE_SEQ_ABORT_EN) stop the sequence early
//   READY        high only while idle
//   BUSY         high whenever not idle
//   DONE         one-cycle pulse when a sequence finishes
//   SLEWRATEENO  registered per-bank enable, bit i -> bank i SLEWRATEENI
//
// Build option:
//   SLEWRATE_SEQ_ABORT_EN  adds the ABORT input. Without it every accepted
//                          sequence runs to completion.

module slewrate_sequencer #(
  parameter int unsigned          NUM_BANKS     = 4,
  parameter int unsigned          SETTLE_CYCLES = 16,
  parameter logic [NUM_BANKS-1:0] INIT_VALUE    = '0
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 REQ,
  input  logic [NUM_BANKS-1:0] TARGET,
`ifdef SLEWRATE_SEQ_ABORT_EN
  input  logic                 ABORT,
`endif
  output logic                 READY,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [NUM_BANKS-1:0] SLEWRATEENO
);

  localparam int unsigned IdxW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BANKS - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StScan   = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NUM_BANKS-1:0] target_q, target_d;
  logic [NUM_BANKS-1:0] out_q, out_d;
  logic                 abort_req;

`ifdef SLEWRATE_SEQ_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    out_d    = out_q;

    unique case (state_q)
      StIdle: begin
        // READY is high throughout idle, so REQ alone means acceptance.
        if (REQ) begin
          target_d = TARGET;
          idx_d    = '0;
          state_d  = StScan;
        end
      end

      StScan: begin
        // Abort wins over a pending write: the current bank stays untouched.
        if (abort_req) begin
          state_d = StDone;
        end else if (target_q[idx_q] != out_q[idx_q]) begin
          out_d[idx_q] = target_q[idx_q];
          cnt_d        = 16'(SETTLE_CYCLES);
          state_d      = StSettle;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      StSettle: begin
        if (abort_req) begin
          state_d = StDone;
        end else if (cnt_q <= 16'd1) begin
          // Last settle cycle: advance to the next bank or finish.
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StScan;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      out_q    <= INIT_VALUE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      out_q    <= out_d;
    end
  end

  assign READY       = (state_q == StIdle);
  assign BUSY        = (state_q != StIdle);
  assign DONE        = (state_q == StDone);
  assign SLEWRATEENO = out_q;

endmodule

// File: tb/tb_slewrate_sequencer.sv
// tb_slewrate_sequencer
//
// Self-checking bench for slewrate_sequencer with NUM_BANKS=4,
// SETTLE_CYCLES=3, INIT_VALUE=0. Each sequence is predicted as a timeline:
// which cycle (relative to acceptance) every changed bank becomes visible and
// which cycle DONE pulses. Outputs are sampled on the falling clock edge.
// The ABORT scenario is built only with SLEWRATE_SEQ_ABORT_EN.

module tb_slewrate_sequencer;

  localparam int N = 4;
  localparam int S = 3;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       REQ;
  logic [3:0] TARGET;
  logic       READY;
  logic       BUSY;
  logic       DONE;
  logic [3:0] SLEWRATEENO;
`ifdef SLEWRATE_SEQ_ABORT_EN
  logic       ABORT;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] model_out;
  logic [3:0] exp_out [0:63];
  int         exp_len;

  always #5 CLK = ~CLK;

  slewrate_sequencer #(
    .NUM_BANKS    (N),
    .SETTLE_CYCLES(S),
    .INIT_VALUE   (4'b0000)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .REQ        (REQ),
    .TARGET     (TARGET),
`ifdef SLEWRATE_SEQ_ABORT_EN
    .ABORT      (ABORT),
`endif
    .READY      (READY),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .SLEWRATEENO(SLEWRATEENO)
  );

  // Timeline model: scan costs one cycle per bank, a changed bank adds S
  // settle cycles and becomes visible the cycle after its scan. An abort at
  // cycle A stops before any bank whose scan is at or after A; DONE at A+1.
  task automatic build_model(input logic [3:0] o, input logic [3:0] t, input int abort_at);
    int         chg [0:3];
    int         c;
    bit         aborted;
    logic [3:0] v;
    c       = 1;
    aborted = 1'b0;
    for (int i = 0; i < N; i++) chg[i] = 0;
    for (int i = 0; i < N; i++) begin
      if (abort_at != 0 && c >= abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (t[i] !== o[i]) begin
        chg[i] = c + 1;
        c      = c + 1 + S;
      end else begin
        c = c + 1;
      end
    end
    if (abort_at != 0 && abort_at < c) aborted = 1'b1;
    exp_len = aborted ? abort_at + 1 : c;
    for (int k = 0; k < 64; k++) begin
      v = o;
      for (int i = 0; i < N; i++) if (chg[i] != 0 && chg[i] <= k) v[i] = t[i];
      exp_out[k] = v;
    end
  endtask

  // junk: 0 = quiet inputs while busy, 1 = random REQ/TARGET, 2 = REQ with 1111.
  // Caller is at a falling edge with the DUT idle. With hold_next the REQ stays
  // high through DONE and the next call starts in the first idle cycle.
  task automatic run_seq(input string name, input logic [3:0] t, input int abort_at,
                         input int junk, input bit hold_next);
    int dones;
    build_model(model_out, t, abort_at);
    dones  = 0;
    REQ    = 1'b1;
    TARGET = t;
    if (READY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_at_accept: got %b want 1", name, READY);
    end
    n_cmp++;
    for (int k = 1; k <= exp_len; k++) begin
      @(negedge CLK);
      if (hold_next) REQ = 1'b1;
      else if (junk == 1) REQ = 1'($urandom_range(0, 1));
      else if (junk == 2) REQ = 1'b1;
      else REQ = 1'b0;
      if (junk == 1) TARGET = 4'($urandom);
      else if (junk == 2) TARGET = 4'b1111;
`ifdef SLEWRATE_SEQ_ABORT_EN
      ABORT = (k == abort_at);
`endif
      if (SLEWRATEENO !== exp_out[k]) begin
        n_fail++;
        $display("FAIL %s out@T+%0d: got %b want %b", name, k, SLEWRATEENO, exp_out[k]);
      end
      n_cmp++;
      if (DONE !== (k == exp_len)) begin
        n_fail++;
        $display("FAIL %s done@T+%0d: got %b want %b", name, k, DONE, (k == exp_len));
      end
      n_cmp++;
      if (BUSY !== 1'b1 || READY !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy/ready@T+%0d: got %b/%b want 1/0", name, k, BUSY, READY);
      end
      n_cmp++;
      if (DONE === 1'b1) dones++;
    end
    if (dones != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d want 1", name, dones);
    end
    n_cmp++;
    @(negedge CLK);
`ifdef SLEWRATE_SEQ_ABORT_EN
    ABORT = 1'b0;
`endif
    model_out = exp_out[exp_len];
    if (!hold_next) begin
      REQ = 1'b0;
      if (READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || SLEWRATEENO !== model_out) begin
        n_fail++;
        $display("FAIL %s after_done: got rdy=%b busy=%b done=%b out=%b want 1 0 0 %b",
                 name, READY, BUSY, DONE, SLEWRATEENO, model_out);
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset();
    REQ    = 1'b0;
    TARGET = 4'b0000;
`ifdef SLEWRATE_SEQ_ABORT_EN
    ABORT  = 1'b0;
`endif
    RSTN   = 1'b0;
    repeat (2) @(negedge CLK);
    if (SLEWRATEENO !== 4'b0000 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got out=%b busy=%b done=%b want 0000 0 0",
               SLEWRATEENO, BUSY, DONE);
    end
    n_cmp++;
    RSTN = 1'b1;
    @(negedge CLK);
    if (SLEWRATEENO !== 4'b0000 || READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got out=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
               SLEWRATEENO, READY, BUSY, DONE);
    end
    n_cmp++;
    model_out = 4'b0000;
  endtask

  task automatic test_directed();
    run_seq("seq_0101", 4'b0101, 0, 0, 1'b0);
  endtask

  task automatic test_skip_all();
    run_seq("skip_0101", 4'b0101, 0, 0, 1'b0);
  endtask

  task automatic test_ignored_req();
    run_seq("ignored_req", 4'b0011, 0, 2, 1'b0);
    if (SLEWRATEENO !== 4'b0011) begin
      n_fail++;
      $display("FAIL ignored_req final: got %b want 0011", SLEWRATEENO);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    test_reset();
    build_model(4'b0000, 4'b0101, 0);
    REQ    = 1'b1;
    TARGET = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      REQ = 1'b0;
      if (SLEWRATEENO !== exp_out[k]) begin
        n_fail++;
        $display("FAIL reset_mid out@T+%0d: got %b want %b", k, SLEWRATEENO, exp_out[k]);
      end
      n_cmp++;
    end
    RSTN = 1'b0;
    #1;
    if (SLEWRATEENO !== 4'b0000 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid async: got out=%b done=%b busy=%b want 0000 0 0",
               SLEWRATEENO, DONE, BUSY);
    end
    n_cmp++;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || READY !== 1'b1 || SLEWRATEENO !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid idle@%0d: got done=%b rdy=%b out=%b want 0 1 0000",
                 k, DONE, READY, SLEWRATEENO);
      end
      n_cmp++;
    end
    model_out = 4'b0000;
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_0", 4'b1010, 0, 0, 1'b1);
    run_seq("b2b_1", 4'b0110, 0, 0, 1'b1);
    run_seq("b2b_2", 4'b1111, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      run_seq($sformatf("rand_%0d", it), 4'($urandom), 0, 1,
              (it < 23) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

`ifdef SLEWRATE_SEQ_ABORT_EN
  task automatic test_abort();
    test_reset();
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    if (READY !== 1'b1 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got rdy=%b done=%b want 1 0", READY, DONE);
    end
    n_cmp++;
    run_seq("abort_1111", 4'b1111, 3, 0, 1'b0);
    if (SLEWRATEENO !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort final: got %b want 0001", SLEWRATEENO);
    end
    n_cmp++;
    for (int it = 0; it < 8; it++) begin
      run_seq($sformatf("abort_rand_%0d", it), 4'($urandom), $urandom_range(1, 12), 0, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_skip_all();
    test_ignored_req();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef SLEWRATE_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/slewrate_sequencer.md
SLEWRATE_SEQUENCER -- requirements
Module: slewrate_sequencer

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of I/O banks driven, 1..16.
REQ-002 Parameter SETTLE_CYCLES, default 16: settle wait after each bank change, 1..65535.
REQ-003 Parameter INIT_VALUE, default all zeros (NUM_BANKS bits): per-bank slew-enable value after reset.
REQ-004 CLK  input  1  rising-edge clock; single clock domain.
REQ-005 RSTN  input  1  reset; asynchronous, active-low.
REQ-006 REQ  input  1  request to apply TARGET.
REQ-007 TARGET  input  NUM_BANKS  requested per-bank slew-enable values.
REQ-008 READY  output  1  high only in IDLE; a request is accepted when REQ and READY are both high.
REQ-009 BUSY  output  1  high in every state except IDLE.
REQ-010 DONE  output  1  one-cycle pulse when the sequence completes.
REQ-011 SLEWRATEENO  output  NUM_BANKS  registered per-bank enable; bit i drives the SLEWRATEENI input of the bank-i controller primitive.

Function
REQ-012 States: IDLE, SCAN, SETTLE, DONE; encoding is free.
REQ-013 IDLE: on REQ&READY, latch TARGET, clear bank index to 0, go to SCAN next cycle.
REQ-014 SCAN, index i: if TARGET_latched[i] equals SLEWRATEENO[i], skip the bank; otherwise write SLEWRATEENO[i] (visible next cycle), load settle counter with SETTLE_CYCLES, go to SETTLE.
REQ-015 Only one SLEWRATEENO bit changes per clock; banks are processed in ascending index order.
REQ-016 SETTLE: hold for exactly SETTLE_CYCLES cycles, then advance the index.
REQ-017 Index advance: if i = NUM_BANKS-1, go to DONE; otherwise go to SCAN with i+1.
REQ-018 DONE: assert DONE for one cycle, then go to IDLE; READY is high in the following cycle.
REQ-019 Latency: with acceptance in cycle T and k changed banks, DONE is high in cycle T+1+NUM_BANKS+k*SETTLE_CYCLES.
REQ-020 REQ while READY=0 is ignored and not queued; TARGET changes after acceptance have no effect.
REQ-021 REQ held high across DONE is accepted in the first IDLE cycle.
REQ-022 Settle counter width is 16 bits; index width is ceil(log2(NUM_BANKS)), minimum 1.

Reset
REQ-023 RSTN low asynchronously forces state IDLE, SLEWRATEENO=INIT_VALUE, index=0, counter=0, DONE=0, BUSY=0; READY=1 once RSTN is high.
REQ-024 Reset mid-sequence discards the latched TARGET; banks already written revert to INIT_VALUE; DONE is not pulsed.

Configuration
REQ-025 Macro SLEWRATE_SEQ_ABORT_EN; when defined, add input ABORT (1 bit).
REQ-026 With the macro: ABORT high in SCAN or SETTLE moves to DONE next cycle; already-written bits keep their new values; remaining banks are untouched; DONE pulses once. ABORT is ignored in IDLE and DONE.
REQ-027 Without the macro: no ABORT port; every accepted sequence runs to completion.

Verification (NUM_BANKS=4, SETTLE_CYCLES=3, INIT_VALUE=4'b0000)
REQ-028 Reset release -> SLEWRATEENO=0000, READY=1, BUSY=0, DONE=0.
REQ-029 REQ, TARGET=0101 accepted at T -> bit0 set visible at T+2, bit2 set visible at T+7, DONE high only at T+11, final output 0101.
REQ-030 REQ, TARGET=0101 with output already 0101 -> no output change, DONE at T+5.
REQ-031 REQ with TARGET=1111 while BUSY -> ignored; the sequence started with 0011 ends with output 0011 and a single DONE pulse.
REQ-032 RSTN low at T+4 during 0101 sequence -> output 0000 immediately, no DONE, READY=1 after release.
REQ-033 (SLEWRATE_SEQ_ABORT_EN) TARGET=1111, ABORT at T+3 -> output 0001, DONE at T+4, READY at T+5.
